// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: master IDs, field widths and the command bundle.
// Used by the arbiter, the SoC top and the DMA block.
package mem_bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic MID_CPU = 1'b0;
    localparam logic MID_AUX = 1'b1;

    typedef struct packed {
        logic              wr;
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } cmd_t;
endpackage

// File: rtl/mem_id_fifo.sv
// Small FIFO of master IDs. Registered push/pop, with the head readable combinationally.
// A push while full or a pop while empty is ignored.
module mem_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter that adds no cycles to the command path. Responses are routed in order through an ID FIFO.
// A stalled grant is locked until the slave accepts it. A full FIFO blocks reads only; writes still pass.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_cmd_valid,
    output logic              m0_cmd_ready,
    input  logic              m0_cmd_wr,
    input  logic              m0_cmd_instr,
    input  logic [ADDR_W-1:0] m0_cmd_addr,
    input  logic [DATA_W-1:0] m0_cmd_wdata,
    input  logic [BE_W-1:0]   m0_cmd_be,
    output logic              m0_rsp_ready,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    input  logic              m1_cmd_valid,
    output logic              m1_cmd_ready,
    input  logic              m1_cmd_wr,
    input  logic              m1_cmd_instr,
    input  logic [ADDR_W-1:0] m1_cmd_addr,
    input  logic [DATA_W-1:0] m1_cmd_wdata,
    input  logic [BE_W-1:0]   m1_cmd_be,
    output logic              m1_rsp_ready,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              s_cmd_valid,
    input  logic              s_cmd_ready,
    output logic              s_cmd_wr,
    output logic              s_cmd_instr,
    output logic [ADDR_W-1:0] s_cmd_addr,
    output logic [DATA_W-1:0] s_cmd_wdata,
    output logic [BE_W-1:0]   s_cmd_be,
    input  logic              s_rsp_ready,
    input  logic [DATA_W-1:0] s_rsp_rdata,
    output logic [CNT_W-1:0]  outstanding,
    output logic              rsp_orphan
);
    cmd_t m0_cmd, m1_cmd, s_cmd;
    logic elig0, elig1, grant, accept;
    logic last_grant, lock, lock_id;
    logic fifo_full, fifo_empty, rsp_pop;
    logic [0:0] head_id;

    assign m0_cmd = '{m0_cmd_wr, m0_cmd_instr, m0_cmd_addr, m0_cmd_wdata, m0_cmd_be};
    assign m1_cmd = '{m1_cmd_wr, m1_cmd_instr, m1_cmd_addr, m1_cmd_wdata, m1_cmd_be};

    assign elig0 = m0_cmd_valid & (m0_cmd_wr | ~fifo_full);
    assign elig1 = m1_cmd_valid & (m1_cmd_wr | ~fifo_full);

    always_comb begin
        grant = MID_CPU;
        if (lock)                grant = lock_id;
        else if (elig0 && elig1) grant = ~last_grant;
        else if (elig1)          grant = MID_AUX;
    end

    assign s_cmd       = grant ? m1_cmd : m0_cmd;
    assign s_cmd_wr    = s_cmd.wr;
    assign s_cmd_instr = s_cmd.instr;
    assign s_cmd_addr  = s_cmd.addr;
    assign s_cmd_wdata = s_cmd.wdata;
    assign s_cmd_be    = s_cmd.be;

    // Gating with reset keeps handshakes from firing while the state is held in reset.
    assign s_cmd_valid  = ~reset & (grant ? elig1 : elig0);
    assign accept       = s_cmd_valid & s_cmd_ready;
    assign m0_cmd_ready = ~reset & (grant == MID_CPU) & s_cmd_ready & elig0;
    assign m1_cmd_ready = ~reset & (grant == MID_AUX) & s_cmd_ready & elig1;

    assign rsp_pop      = ~reset & s_rsp_ready & ~fifo_empty;
    assign m0_rsp_ready = rsp_pop & (head_id == MID_CPU);
    assign m1_rsp_ready = rsp_pop & (head_id == MID_AUX);
    assign m0_rsp_rdata = s_rsp_rdata;
    assign m1_rsp_rdata = s_rsp_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= MID_AUX;
            lock       <= 1'b0;
            lock_id    <= MID_CPU;
            rsp_orphan <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                lock       <= 1'b0;
            end else if (s_cmd_valid) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end else begin
                lock <= 1'b0;
            end
            if (s_rsp_ready && fifo_empty) rsp_orphan <= 1'b1;
        end
    end

    mem_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept & ~s_cmd.wr),
        .push_dat (grant),
        .pop      (rsp_pop),
        .pop_dat  (head_id),
        .count    (outstanding),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with hand-computed expectations.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_wr, m0_cmd_instr;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata;
    logic [3:0]  m0_cmd_be;
    logic        m0_rsp_ready;
    logic [31:0] m0_rsp_rdata;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_wr, m1_cmd_instr;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata;
    logic [3:0]  m1_cmd_be;
    logic        m1_rsp_ready;
    logic [31:0] m1_rsp_rdata;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_wr, s_cmd_instr;
    logic [31:0] s_cmd_addr, s_cmd_wdata;
    logic [3:0]  s_cmd_be;
    logic        s_rsp_ready;
    logic [31:0] s_rsp_rdata;
    logic [2:0]  outstanding;
    logic        rsp_orphan;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
        .m0_cmd_instr(m0_cmd_instr), .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata),
        .m0_cmd_be(m0_cmd_be), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
        .m1_cmd_instr(m1_cmd_instr), .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata),
        .m1_cmd_be(m1_cmd_be), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
        .s_cmd_instr(s_cmd_instr), .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata),
        .s_cmd_be(s_cmd_be), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .outstanding(outstanding), .rsp_orphan(rsp_orphan)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_cmd_valid = 0; m0_cmd_wr = 0; m0_cmd_instr = 0;
        m0_cmd_addr = '0; m0_cmd_wdata = '0; m0_cmd_be = 4'hF;
        m1_cmd_valid = 0; m1_cmd_wr = 0; m1_cmd_instr = 0;
        m1_cmd_addr = '0; m1_cmd_wdata = '0; m1_cmd_be = 4'hF;
        s_cmd_ready = 0; s_rsp_ready = 0; s_rsp_rdata = '0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) step();
        reset = 0;
        #1;
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_orphan", 32'(rsp_orphan), 0);
        check("rst_s_valid", 32'(s_cmd_valid), 0);
        check("rst_m0_rsp", 32'(m0_rsp_ready), 0);

        // Solo m0 read at 0x100, answered two cycles after acceptance.
        step();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h100; s_cmd_ready = 1;
        #1;
        check("solo_m0_ready", 32'(m0_cmd_ready), 1);
        check("solo_s_valid", 32'(s_cmd_valid), 1);
        check("solo_s_addr", s_cmd_addr, 32'h100);
        step();
        m0_cmd_valid = 0;
        #1;
        check("solo_outst1", 32'(outstanding), 1);
        step();
        s_rsp_ready = 1; s_rsp_rdata = 32'hDEADBEEF;
        #1;
        check("solo_m0_rsp", 32'(m0_rsp_ready), 1);
        check("solo_m1_rsp", 32'(m1_rsp_ready), 0);
        check("solo_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        step();
        s_rsp_ready = 0;
        #1;
        check("solo_outst0", 32'(outstanding), 0);
        check("solo_m0_rsp_off", 32'(m0_rsp_ready), 0);

        // Both masters read continuously; grants alternate 0,1,0,1...
        do_reset();
        for (int i = 0; i < 8; i++) begin
            m0_cmd_valid = 1; m0_cmd_addr = 32'h1000;
            m1_cmd_valid = 1; m1_cmd_addr = 32'h2000;
            s_cmd_ready = 1;
            s_rsp_ready = (i > 0);
            s_rsp_rdata = 32'hA000_0000 + 32'(i);
            #1;
            check($sformatf("rr_m0_ready_%0d", i), 32'(m0_cmd_ready), 32'(i % 2 == 0));
            check($sformatf("rr_m1_ready_%0d", i), 32'(m1_cmd_ready), 32'(i % 2 == 1));
            if (i > 0) begin
                check($sformatf("rr_m0_rsp_%0d", i), 32'(m0_rsp_ready), 32'((i - 1) % 2 == 0));
                check($sformatf("rr_m1_rsp_%0d", i), 32'(m1_rsp_ready), 32'((i - 1) % 2 == 1));
            end
            step();
        end
        m0_cmd_valid = 0; m1_cmd_valid = 0;
        s_rsp_ready = 1; s_rsp_rdata = 32'hA000_0008;
        #1;
        check("rr_last_m1_rsp", 32'(m1_rsp_ready), 1);
        check("rr_last_m0_rsp", 32'(m0_rsp_ready), 0);
        check("rr_last_rdata", m1_rsp_rdata, 32'hA000_0008);
        step();
        s_rsp_ready = 0;
        #1;
        check("rr_drained", 32'(outstanding), 0);

        // m1 write stalled by the slave keeps the grant despite m0 contending.
        do_reset();
        m1_cmd_valid = 1; m1_cmd_wr = 1; m1_cmd_addr = 32'h200; m1_cmd_wdata = 32'h1234;
        #1;
        check("lk_s_valid", 32'(s_cmd_valid), 1);
        check("lk_s_wr", 32'(s_cmd_wr), 1);
        check("lk_m1_ready_stall", 32'(m1_cmd_ready), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            m0_cmd_valid = 1; m0_cmd_addr = 32'h300;
            #1;
            check($sformatf("lk_hold_addr_%0d", i), s_cmd_addr, 32'h200);
            check($sformatf("lk_m0_ready_%0d", i), 32'(m0_cmd_ready), 0);
        end
        step();
        s_cmd_ready = 1;
        #1;
        check("lk_m1_accept", 32'(m1_cmd_ready), 1);
        check("lk_m0_wait", 32'(m0_cmd_ready), 0);
        step();
        m1_cmd_valid = 0;
        #1;
        check("lk_m0_accept", 32'(m0_cmd_ready), 1);
        check("lk_m0_addr", s_cmd_addr, 32'h300);
        step();
        m0_cmd_valid = 0;
        #1;
        check("lk_outst", 32'(outstanding), 1);

        // Fill the FIFO: reads stall, writes still pass.
        do_reset();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h500; s_cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("full_fill_%0d", i), 32'(m0_cmd_ready), 1);
            step();
        end
        m1_cmd_valid = 1; m1_cmd_wr = 1; m1_cmd_addr = 32'h400;
        #1;
        check("full_outst4", 32'(outstanding), 4);
        check("full_m0_blocked", 32'(m0_cmd_ready), 0);
        check("full_m1_write", 32'(m1_cmd_ready), 1);
        check("full_s_addr", s_cmd_addr, 32'h400);
        step();
        m1_cmd_valid = 0;
        s_rsp_ready = 1; s_rsp_rdata = 32'h55;
        #1;
        check("full_after_wr", 32'(outstanding), 4);
        check("full_m0_still", 32'(m0_cmd_ready), 0);
        check("full_rsp_m0", 32'(m0_rsp_ready), 1);
        step();
        s_rsp_ready = 0;
        #1;
        check("full_outst3", 32'(outstanding), 3);
        check("full_m0_accept", 32'(m0_cmd_ready), 1);
        step();
        m0_cmd_valid = 0;
        #1;
        check("full_outst4b", 32'(outstanding), 4);

        // Orphan response, then asynchronous reset in mid-stream.
        do_reset();
        s_rsp_ready = 1; s_rsp_rdata = 32'h77;
        #1;
        check("orph_m0_rsp", 32'(m0_rsp_ready), 0);
        check("orph_m1_rsp", 32'(m1_rsp_ready), 0);
        step();
        s_rsp_ready = 0;
        #1;
        check("orph_set", 32'(rsp_orphan), 1);
        step();
        #1;
        check("orph_sticky", 32'(rsp_orphan), 1);
        m0_cmd_valid = 1; m0_cmd_addr = 32'h600; s_cmd_ready = 1;
        step();
        #1;
        check("mid_outst1", 32'(outstanding), 1);
        check("mid_s_valid", 32'(s_cmd_valid), 1);
        reset = 1;
        #1;
        check("mid_rst_outst", 32'(outstanding), 0);
        check("mid_rst_orphan", 32'(rsp_orphan), 0);
        check("mid_rst_s_valid", 32'(s_cmd_valid), 0);
        step();
        reset = 0;
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU memory bus (cmd valid/ready, single-cycle rsp_ready pulse with rdata).
- Master 0 is the CPU; master 1 is a secondary bus master (DMA or debug loader).
- The slave port drives the existing SoC address decoder, local RAM and GPIO unchanged.
- Round-robin grant on contention, zero added latency on the command path, in-order read-response routing through an outstanding-ID FIFO.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-unanswered reads; power of 2, minimum 2
CNT_W, $clog2(MAX_OUTSTANDING)+1, width of outstanding count (localparam)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
m0_cmd_valid / m1_cmd_valid  in  1  master command valid
m0_cmd_ready / m1_cmd_ready  out  1  command accepted this cycle
m0_cmd_wr / m1_cmd_wr  in  1  1 = write, 0 = read
m0_cmd_instr / m1_cmd_instr  in  1  instruction-fetch qualifier, passed through
m0_cmd_addr / m1_cmd_addr  in  32  byte address
m0_cmd_wdata / m1_cmd_wdata  in  32  write data
m0_cmd_be / m1_cmd_be  in  4  byte enables
m0_rsp_ready / m1_rsp_ready  out  1  read response valid for this master (1-cycle pulse)
m0_rsp_rdata / m1_rsp_rdata  out  32  read data; copy of s_rsp_rdata, qualified by rsp_ready
s_cmd_valid, s_cmd_wr, s_cmd_instr  out  1  muxed command to slave
s_cmd_addr, s_cmd_wdata  out  32  muxed command fields
s_cmd_be  out  4  muxed byte enables
s_cmd_ready  in  1  slave accepts command
s_rsp_ready  in  1  slave read-response pulse
s_rsp_rdata  in  32  slave read data
outstanding  out  CNT_W  reads in flight
rsp_orphan  out  1  sticky error: response received with no read outstanding

Behaviour:
- Reset (asynchronous, active-high): grant state = master 0 has priority (last_grant=1); lock clear; FIFO empty; outstanding=0; rsp_orphan=0. All outputs are combinational from these states, so s_cmd_valid=0 and m*_rsp_ready=0 whenever no master is requesting or responding.
- Eligibility: a master is eligible when its cmd_valid=1 and either cmd_wr=1 or the FIFO is not full. A full FIFO blocks reads only; writes still pass.
- Grant, combinational:
  - If locked, the locked master is granted.
  - Otherwise, a single eligible master is granted.
  - If both are eligible, the master that is not last_grant is granted.
- Lock: set when the granted master presents s_cmd_valid=1 and s_cmd_ready=0. Cleared on acceptance. Masters must hold cmd fields stable while unaccepted; the lock prevents grant switching mid-handshake.
- s_cmd_* = fields of the granted master. s_cmd_valid = granted master eligible. mN_cmd_ready = (grant==N) & s_cmd_ready & eligible. The ungranted master sees ready=0.
- Accept (s_cmd_valid & s_cmd_ready): last_grant <= granted ID. If read, push the ID into the FIFO. Zero added cycles; an accepted command reaches the slave in the same cycle.
- Response (s_rsp_ready=1): pop the FIFO head ID. The same cycle, assert m[head]_rsp_ready; the other master's rsp_ready stays 0. rdata is broadcast to both masters.
- Simultaneous push and pop: legal in any state except full, where the push is blocked by the eligibility rule. outstanding is unchanged.
- Response with FIFO empty: dropped (no mN_rsp_ready), rsp_orphan <= 1, held until reset.
- Responses are strictly in order; the slave guarantees in-order return.
- outstanding = FIFO count. It stays in 0..MAX_OUTSTANDING; no wrap beyond MAX_OUTSTANDING.
- Reset mid-transaction: the FIFO is flushed. Slave responses arriving after reset for pre-reset reads set rsp_orphan. The system resets slave and arbiter together, so this does not occur in normal use.

Decomposition:
- Package mem_bus_pkg: master ID constants (MID_CPU=0, MID_AUX=1) and a cmd field-width constant (ADDR_W=32, DATA_W=32, BE_W=4), shared with the SoC top and the future DMA block.
- Sub-module mem_id_fifo: DEPTH=MAX_OUTSTANDING, WIDTH=1, synchronous push/pop, async-reset pointers, count/full/empty outputs, wrapping read/write pointers.

Test Plan:
- Solo m0 read at 0x100, slave ready=1, response 2 cycles later with rdata=0xDEADBEEF -> m0_cmd_ready the same cycle; m0_rsp_ready pulses once with 0xDEADBEEF; m1_rsp_ready stays 0; outstanding goes 0→1→0.
- Both masters continuously issue reads for 8 accepted commands -> grant sequence 0,1,0,1,0,1,0,1; responses routed in the same order.
- m1 write held with s_cmd_ready=0 for 3 cycles while m0 raises valid -> grant stays m1 (lock) until acceptance; m0 is accepted the next cycle.
- 4 reads issued with no responses (full) -> a 5th read sees cmd_ready=0 and a write proceeds. One response frees a slot; the read is accepted the following cycle with outstanding=4.
- Assert s_rsp_ready with the FIFO empty -> no mN_rsp_ready; rsp_orphan=1 and stays 1. Assert reset mid-stream -> outstanding=0, rsp_orphan=0, s_cmd_valid=0 immediately (async).
